traffic_matrix_ctrl: RTL
========================

Name: traffic_matrix_ctrl

Overview:
- Controller for the 16x16 pedestrian-signal dot matrix.
- Drives one shared 4-bit row index to four combinational pattern ROMs: three walking frames and one standing figure.
- Muxes the selected ROM column word to the matrix, scans rows, and animates frames.
- Runs the pedestrian WALK/FLASH/STOP timing with a push-button shortcut.

Parameters:
- SCAN_DIV, 5000: clk cycles per row (must be >= 1).
- TICK_DIV, 50000000: clk cycles per one-second tick.
- ANIM_FRAMES, 8: full 16-row scans per walking-animation step.
- WALK_TIME, 20: seconds in WALK.
- FLASH_TIME, 5: seconds in FLASH.
- STOP_TIME, 30: seconds in STOP.
- SHORT_TIME, 3: STOP remaining seconds after a pedestrian request.
- All *_TIME values are 1..99.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous, active-low reset
- ped_req  in  1  pedestrian button, synchronous level
- pat_walk0  in  16  column word from walking frame 0 ROM
- pat_walk1  in  16  column word from walking frame 1 ROM
- pat_walk2  in  16  column word from walking frame 2 ROM
- pat_stop  in  16  column word from standing-figure ROM
- row_bin  out  4  row index to all pattern ROMs, registered
- row_sel  out  16  one-hot row drive, bit n = row n, registered
- col_out  out  16  column drive for the current row
- led_green  out  1  green pedestrian lamp
- led_red  out  1  red pedestrian lamp

Behaviour:
- One clock: clk. Reset is synchronous and active-low: rst_n sampled on the rising clk edge, and rst_n=0 forces reset state.
- Reset values:
  - state=STOP, sec_left=STOP_TIME, frame=0, blank=0.
  - scan_cnt=0, tick_cnt=0, anim_cnt=0.
  - row_bin=0, row_sel=16'h0001, led_red=1, led_green=0.
  - col_out therefore equals pat_stop for row 0.
- Reset mid-operation aborts any state and timer immediately on the next edge.
- Row scan:
  - scan_cnt counts 0..SCAN_DIV-1.
  - At terminal count, row_bin <= row_bin+1 (wraps 15->0) and row_sel <= one-hot of the new row.
  - row_bin and row_sel always change on the same edge. row_sel is never zero and never has more than one bit set.
- Frame done: a one-cycle internal pulse when row_bin wraps 15->0.
- Column mux: col_out is combinational from the ROM inputs, selected by registered state/frame, ANDed with ~blank.
  - Latency: col_out is valid in the same cycle row_bin changes (the ROMs are combinational).
- Second tick: tick_cnt counts 0..TICK_DIV-1 and pulses at terminal count. It runs free and is not restarted on state change.
- State machine (sec_left is a 7-bit down-counter, loaded on state entry):
  - STOP: pattern pat_stop, led_red=1, led_green=0.
    - On tick: if sec_left==1, go to WALK and load WALK_TIME; else decrement.
  - WALK: led_green=1, led_red=0.
    - Pattern is pat_walk{frame}.
    - anim_cnt counts frame-done pulses 0..ANIM_FRAMES-1. At terminal count, frame advances 0->1->2->0.
    - On tick with sec_left==1: go to FLASH, load FLASH_TIME.
  - FLASH: frame held at 0 with pattern pat_walk0.
    - blank = ~sec_left[0], so the display is dark while sec_left is even.
    - led_green = sec_left[0], led_red=0.
    - On tick with sec_left==1: go to STOP, load STOP_TIME, blank=0.
- Entering WALK clears frame and anim_cnt to 0.
- blank is forced to 0 outside FLASH.
- ped_req:
  - Honoured only in STOP with sec_left > SHORT_TIME. It loads sec_left=SHORT_TIME, and any tick in the same cycle is ignored.
  - Ignored in WALK and FLASH, and in STOP when sec_left <= SHORT_TIME.
  - A held button has no further effect once sec_left <= SHORT_TIME.
- State and timer updates never stall the row scan. A state change mid-frame switches the pattern from the next row onward; no frame alignment is required.

Optional Feature:
- Macro: TRAFFIC_COUNTDOWN_EN.
- Defined:
  - Adds output sec_left_bcd (8 bits: tens nibble, ones nibble), registered.
  - It equals the BCD of sec_left and updates on the same edge as sec_left.
  - Reset value is the BCD of STOP_TIME.
  - In FLASH it shows the value even while blank=1.
- Undefined: the port and BCD logic are absent, and all other behaviour is identical.

Test Plan:
1. Reset and scan. Parameters SCAN_DIV=2, TICK_DIV=64, ANIM_FRAMES=1, WALK_TIME=3, FLASH_TIME=2, STOP_TIME=4, SHORT_TIME=1. Hold rst_n=0 for 3 cycles, then release.
   - row_bin=0, row_sel=16'h0001, led_red=1, col_out=pat_stop.
   - row_bin steps every 2 cycles through 15 and wraps to 0; row_sel=16'h8000 at row 15.
2. Full cycle, no button.
   - STOP lasts 4 ticks (256 cycles), then led_green=1.
   - WALK lasts 3 ticks; frame advances every 32 cycles as 0,1,2,0,...
   - FLASH lasts 2 ticks: first second blank=1 (sec_left=2, col_out=0, led_green=0), second second col_out=pat_walk0, led_green=1.
   - Then back to STOP with sec_left=4.
3. ped_req in STOP with sec_left=4 → sec_left=1, WALK entered on the next tick.
   - ped_req asserted coincident with a tick → sec_left=1, not 3.
4. ped_req held high through WALK and FLASH → no timing change.
   - ped_req in STOP at sec_left=1 → no change.
5. rst_n=0 for one cycle mid-WALK at row 9 → next cycle state=STOP, row_bin=0, frame=0, led_red=1.
6. With TRAFFIC_COUNTDOWN_EN and STOP_TIME=30 → sec_left_bcd=8'h30 after reset, 8'h29 after the first tick.

Source files
------------

// File: rtl/traffic_matrix_ctrl.sv
// Pedestrian-signal dot-matrix controller: row scan, ROM column mux,
// frame animation and WALK/FLASH/STOP timing with push-button shortcut.
// Ports: clk, rst_n (sync, active-low), ped_req, pat_walk0..2, pat_stop in;
//   row_bin, row_sel, col_out, led_green, led_red out.
// Optional: define TRAFFIC_COUNTDOWN_EN to add registered sec_left_bcd output.
module traffic_matrix_ctrl #(
   parameter int SCAN_DIV    = 5000,
   parameter int TICK_DIV    = 50000000,
   parameter int ANIM_FRAMES = 8,
   parameter int WALK_TIME   = 20,
   parameter int FLASH_TIME  = 5,
   parameter int STOP_TIME   = 30,
   parameter int SHORT_TIME  = 3
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ped_req,
   input  logic [15:0] pat_walk0,
   input  logic [15:0] pat_walk1,
   input  logic [15:0] pat_walk2,
   input  logic [15:0] pat_stop,
   output logic [3:0]  row_bin,
   output logic [15:0] row_sel,
   output logic [15:0] col_out,
   output logic        led_green,
   output logic        led_red
`ifdef TRAFFIC_COUNTDOWN_EN
   ,
   output logic [7:0]  sec_left_bcd
`endif
);

   localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int AW = (ANIM_FRAMES > 1) ? $clog2(ANIM_FRAMES) : 1;

   typedef enum logic [1:0] {
      ST_STOP,
      ST_WALK,
      ST_FLASH
   } state_t;

   state_t        state_q, state_d;
   logic [6:0]    sec_q, sec_d;
   logic [1:0]    frame_q, frame_d;
   logic [AW-1:0] anim_q, anim_d;
   logic [SW-1:0] scan_cnt;
   logic [TW-1:0] tick_cnt;
   logic          scan_tc;
   logic          frame_done;
   logic          tick;
   logic          blank;
   logic [15:0]   pat;

   assign scan_tc    = (scan_cnt == SW'(SCAN_DIV - 1));
   assign frame_done = scan_tc && (row_bin == 4'd15);
   assign tick       = (tick_cnt == TW'(TICK_DIV - 1));

   // Row scan and the free-running second prescaler; neither is ever
   // held off by the state machine.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         scan_cnt <= '0;
         tick_cnt <= '0;
         row_bin  <= 4'd0;
         row_sel  <= 16'h0001;
      end else begin
         tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
         if (scan_tc) begin
            scan_cnt <= '0;
            row_bin  <= row_bin + 4'd1;
            // Rotating the one-hot keeps it aligned with row_bin + 1.
            row_sel  <= {row_sel[14:0], row_sel[15]};
         end else begin
            scan_cnt <= scan_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_STOP;
         sec_q   <= 7'(STOP_TIME);
         frame_q <= 2'd0;
         anim_q  <= '0;
      end else begin
         state_q <= state_d;
         sec_q   <= sec_d;
         frame_q <= frame_d;
         anim_q  <= anim_d;
      end
   end

   always_comb begin
      state_d = state_q;
      sec_d   = sec_q;
      frame_d = frame_q;
      anim_d  = anim_q;
      unique case (state_q)
         ST_STOP: begin
            // The button shortcut takes priority over a same-cycle tick.
            if (ped_req && (sec_q > 7'(SHORT_TIME))) begin
               sec_d = 7'(SHORT_TIME);
            end else if (tick) begin
               if (sec_q == 7'd1) begin
                  state_d = ST_WALK;
                  sec_d   = 7'(WALK_TIME);
                  frame_d = 2'd0;
                  anim_d  = '0;
               end else begin
                  sec_d = sec_q - 7'd1;
               end
            end
         end
         ST_WALK: begin
            if (frame_done) begin
               if (anim_q == AW'(ANIM_FRAMES - 1)) begin
                  anim_d  = '0;
                  frame_d = (frame_q == 2'd2) ? 2'd0 : frame_q + 2'd1;
               end else begin
                  anim_d = anim_q + 1'b1;
               end
            end
            if (tick) begin
               if (sec_q == 7'd1) begin
                  state_d = ST_FLASH;
                  sec_d   = 7'(FLASH_TIME);
                  frame_d = 2'd0;
                  anim_d  = '0;
               end else begin
                  sec_d = sec_q - 7'd1;
               end
            end
         end
         ST_FLASH: begin
            frame_d = 2'd0;
            if (tick) begin
               if (sec_q == 7'd1) begin
                  state_d = ST_STOP;
                  sec_d   = 7'(STOP_TIME);
               end else begin
                  sec_d = sec_q - 7'd1;
               end
            end
         end
         default: state_d = ST_STOP;
      endcase
   end

   // Dark on even seconds while flashing.
   assign blank     = (state_q == ST_FLASH) && !sec_q[0];
   assign led_red   = (state_q == ST_STOP);
   assign led_green = (state_q == ST_WALK) ||
                      ((state_q == ST_FLASH) && sec_q[0]);

   always_comb begin
      pat = pat_stop;
      case (state_q)
         ST_WALK: begin
            case (frame_q)
               2'd1:    pat = pat_walk1;
               2'd2:    pat = pat_walk2;
               default: pat = pat_walk0;
            endcase
         end
         ST_FLASH: pat = pat_walk0;
         default:  pat = pat_stop;
      endcase
      col_out = pat & {16{~blank}};
   end

`ifdef TRAFFIC_COUNTDOWN_EN
   function automatic logic [7:0] to_bcd(input logic [6:0] v);
      return {4'(v / 7'd10), 4'(v % 7'd10)};
   endfunction

   // Tracks sec_d so the BCD and sec_left change on the same edge.
   always_ff @(posedge clk) begin
      if (!rst_n) sec_left_bcd <= to_bcd(7'(STOP_TIME));
      else        sec_left_bcd <= to_bcd(sec_d);
   end
`endif

endmodule
